ppc405_dcr_ctrl: RTL and testbench
==================================

// Module: ppc405_dcr_ctrl
// PURPOSE
//  DCR bus controller between the PPC405 DCR master port and four DCR slaves.
//  Decodes C405DCRABUS[0:1] to a slave and sequences one-hot slave strobes.
//  Bounds each access with a timeout, then returns a single-cycle DCRC405ACK with read data.
//  Sits beside the core in the processor wrapper; all DCR peripherals hang off it.
// PARAMETERS
//  TIMEOUT_CYC   16   cycles in ACCESS without slave ack before forced completion; legal 2..255
//  TO_RDDATA     32'h0000_0000   read data returned on timeout or protocol error
// PORTS
//  DCRCLK         in   1       DCR clock, all state on rising edge
//  DCRRSTNEG      in   1       asynchronous active-low reset
//  C405DCRREAD    in   1       core read request, level, held until ack
//  C405DCRWRITE   in   1       core write request, level, held until ack
//  C405DCRABUS    in   [0:9]   DCR address; [0:1] slave select, [2:9] slave-local address
//  C405DCRDBUSOUT in   [0:31]  core write data
//  DCRC405ACK     out  1       one-cycle completion pulse to core
//  DCRC405DBUSIN  out  [0:31]  read data to core, valid with ACK, held afterwards
//  DCRTIMEOUT     out  1       one-cycle pulse coincident with a timeout ACK
//  SLVDCRREAD     out  [0:3]   one-hot slave read strobe, bit i = slave i
//  SLVDCRWRITE    out  [0:3]   one-hot slave write strobe
//  SLVDCRABUS     out  [0:7]   registered slave-local address
//  SLVDCRDBUS     out  [0:31]  registered write data
//  SLVDCRACK      in   [0:3]   per-slave ack, level or pulse
//  SLVDCRRDDBUS   in   [0:127] slave i read data on bits [32*i : 32*i+31]
// BEHAVIOUR
//  - Reset (async, DCRRSTNEG=0): FSM=IDLE; timeout counter=0; all outputs 0, incl. DCRC405DBUSIN.
//  - FSM states and transitions:
//      IDLE    -> ACCESS  on exactly one of READ/WRITE set; latch addr, data, dir, slave index.
//      IDLE    -> DONE    on READ & WRITE both set (protocol error); no slave strobe; data=TO_RDDATA.
//      ACCESS  -> DONE    on SLVDCRACK[sel]=1; capture SLVDCRRDDBUS slice on reads.
//      ACCESS  -> DONE    on count==TIMEOUT_CYC-1 and no ack; data=TO_RDDATA; DCRTIMEOUT=1 in DONE.
//      ACCESS  -> IDLE    if the core drops both READ and WRITE (abort); no ACK issued.
//      DONE    -> RELEASE unconditionally; DCRC405ACK=1 for exactly this one cycle.
//      RELEASE -> IDLE    once READ=0 and WRITE=0; a request held high never re-triggers.
//  - Strobes: SLVDCRREAD/WRITE[sel] are registered, high in every ACCESS cycle, 0 in all other states.
//    At most one bit of SLVDCRREAD|SLVDCRWRITE is ever set.
//  - Latency: request seen at edge k -> strobe from k+1. With the slave acking in its first strobe
//    cycle, DCRC405ACK is high in cycle k+2 (minimum 2-cycle access).
//  - Acks from unselected slaves are ignored. An ack on the same edge as the timeout terminal count wins:
//    slave data is returned, no DCRTIMEOUT.
//  - Write ACK: DCRC405DBUSIN <= latched write data (echo).
//    Read ACK: DCRC405DBUSIN <= captured data. Value holds until the next ACK.
//  - Timeout counter: 8 bits, cleared on ACCESS entry, +1 per ACCESS cycle, never wraps.
//  - Changing address or data mid-access has no effect; the values latched at IDLE->ACCESS are used.
//  - Reset asserted mid-access: immediate return to IDLE, strobes drop asynchronously, no ACK.
// CONFIGURATION
//  PPC405_DCR_ERRLOG_EN defined: adds outputs DCRERRADDR [0:9] and DCRERRCNT [0:7].
//    On every timeout or protocol-error ACK, DCRERRADDR <= latched address.
//    DCRERRCNT increments and saturates at 8'hFF. Both reset to 0.
//  Not defined: these ports and registers do not exist; all other behaviour is identical.
// TESTING
//  - Write 0x2A5 with data 0xCAFE_F00D, slave 2 acks in its first strobe cycle
//      -> SLVDCRWRITE=4'b0010 for 1 cycle, SLVDCRABUS=0xA5, SLVDCRDBUS=0xCAFEF00D;
//         ACK 2 cycles after the request; DBUSIN=0xCAFEF00D.
//  - Read 0x013, slave 0 drives 0x1234_5678 and acks after 3 cycles
//      -> ACK in cycle 5 with DBUSIN=0x12345678; ACK stays low until READ drops and is re-raised.
//  - Read 0x3FF with no slave ack, TIMEOUT_CYC=16
//      -> strobe for 16 cycles; ACK and DCRTIMEOUT together in the next cycle; DBUSIN=0.
//      -> with ERRLOG: DCRERRADDR=0x3FF, DCRERRCNT=1.
//  - READ and WRITE raised together -> no slave strobe; ACK in the next cycle; DBUSIN=TO_RDDATA.
//  - SLVDCRACK[1] pulsed during an access to slave 3 -> ignored; access times out.
//  - DCRRSTNEG pulsed low in the 2nd ACCESS cycle -> strobes 0 immediately; FSM=IDLE; no ACK.
//    Next request completes normally.
//  - ERRLOG build: 260 consecutive timeouts -> DCRERRCNT holds at 8'hFF.

Source files
------------

// File: rtl/ppc405_dcr_ctrl.sv
// DCR bus controller: decodes the PPC405 DCR master request onto four one-hot slave strobes,
// bounds each access with a timeout and returns a one-cycle ACK. Optional macro: PPC405_DCR_ERRLOG_EN.
module ppc405_dcr_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 16,
    parameter logic [0:31] TO_RDDATA   = 32'h0000_0000
) (
    input  logic          DCRCLK,
    input  logic          DCRRSTNEG,
    input  logic          C405DCRREAD,
    input  logic          C405DCRWRITE,
    input  logic [0:9]    C405DCRABUS,
    input  logic [0:31]   C405DCRDBUSOUT,
    output logic          DCRC405ACK,
    output logic [0:31]   DCRC405DBUSIN,
    output logic          DCRTIMEOUT,
    output logic [0:3]    SLVDCRREAD,
    output logic [0:3]    SLVDCRWRITE,
    output logic [0:7]    SLVDCRABUS,
    output logic [0:31]   SLVDCRDBUS,
    input  logic [0:3]    SLVDCRACK,
    input  logic [0:127]  SLVDCRRDDBUS
`ifdef PPC405_DCR_ERRLOG_EN
    ,
    output logic [0:9]    DCRERRADDR,
    output logic [0:7]    DCRERRCNT
`endif
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE, RELEASE} state_t;

    state_t      state_q, state_d;
    logic [1:0]  sel_q, sel_d;
    logic        wr_q, wr_d;
    logic [7:0]  count_q;
    logic        timeout_d;
    logic        proto_err;
    logic        slv_ack;
    logic        terminal;
    logic        req_none;
    logic [0:31] rd_slice;
    logic [0:3]  strobe_d;

    assign req_none  = !C405DCRREAD && !C405DCRWRITE;
    assign proto_err = (state_q == IDLE) && C405DCRREAD && C405DCRWRITE;
    assign slv_ack   = SLVDCRACK[sel_q];
    assign terminal  = (count_q == 8'(TIMEOUT_CYC - 1));

    always_comb begin
        rd_slice = SLVDCRRDDBUS[0:31];
        case (sel_q)
            2'd1:    rd_slice = SLVDCRRDDBUS[32:63];
            2'd2:    rd_slice = SLVDCRRDDBUS[64:95];
            2'd3:    rd_slice = SLVDCRRDDBUS[96:127];
            default: rd_slice = SLVDCRRDDBUS[0:31];
        endcase
    end

    // A selected-slave ack is checked before the terminal count so it wins a tie.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        wr_d      = wr_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (proto_err) begin
                    state_d = DONE;
                end else if (C405DCRREAD || C405DCRWRITE) begin
                    state_d = ACCESS;
                    sel_d   = C405DCRABUS[0:1];
                    wr_d    = C405DCRWRITE;
                end
            end
            ACCESS: begin
                if (slv_ack) begin
                    state_d = DONE;
                end else if (terminal) begin
                    state_d   = DONE;
                    timeout_d = 1'b1;
                end else if (req_none) begin
                    state_d = IDLE;
                end
            end
            DONE:    state_d = RELEASE;
            RELEASE: if (req_none) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        strobe_d = (state_d == ACCESS) ? (4'b1000 >> sel_d) : 4'b0000;
    end

    always_ff @(posedge DCRCLK or negedge DCRRSTNEG) begin
        if (!DCRRSTNEG) begin
            state_q       <= IDLE;
            sel_q         <= 2'd0;
            wr_q          <= 1'b0;
            count_q       <= 8'd0;
            SLVDCRREAD    <= 4'b0000;
            SLVDCRWRITE   <= 4'b0000;
            SLVDCRABUS    <= 8'h00;
            SLVDCRDBUS    <= 32'h0;
            DCRC405ACK    <= 1'b0;
            DCRTIMEOUT    <= 1'b0;
            DCRC405DBUSIN <= 32'h0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            wr_q        <= wr_d;
            SLVDCRREAD  <= wr_d ? 4'b0000 : strobe_d;
            SLVDCRWRITE <= wr_d ? strobe_d : 4'b0000;
            DCRC405ACK  <= (state_d == DONE);
            DCRTIMEOUT  <= timeout_d;
            if (state_q != ACCESS)
                count_q <= 8'd0;
            else if (count_q != 8'hFF)
                count_q <= count_q + 8'd1;
            if (state_q == IDLE && state_d == ACCESS) begin
                SLVDCRABUS <= C405DCRABUS[2:9];
                SLVDCRDBUS <= C405DCRDBUSOUT;
            end
            // Writes echo the latched write data back to the core.
            if (proto_err || timeout_d)
                DCRC405DBUSIN <= TO_RDDATA;
            else if (state_q == ACCESS && slv_ack)
                DCRC405DBUSIN <= wr_q ? SLVDCRDBUS : rd_slice;
        end
    end

`ifdef PPC405_DCR_ERRLOG_EN
    always_ff @(posedge DCRCLK or negedge DCRRSTNEG) begin
        if (!DCRRSTNEG) begin
            DCRERRADDR <= 10'h000;
            DCRERRCNT  <= 8'h00;
        end else if (proto_err || timeout_d) begin
            DCRERRADDR <= proto_err ? C405DCRABUS : {sel_q, SLVDCRABUS};
            if (DCRERRCNT != 8'hFF)
                DCRERRCNT <= DCRERRCNT + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ppc405_dcr_ctrl.sv
// Scoreboard bench for ppc405_dcr_ctrl: driver pushes expected ACK responses, a negedge monitor
// pops and compares them; randomized transactions plus the directed corner cases.
module tb_ppc405_dcr_ctrl;

    localparam int          TIMEOUT_CYC = 16;
    localparam logic [31:0] TO_RDDATA   = 32'h0000_0000;

    localparam int KREAD    = 0;
    localparam int KWRITE   = 1;
    localparam int KTIMEOUT = 2;
    localparam int KBOTH    = 3;
    localparam int KSPUR    = 4;
    localparam int KABORT   = 5;

    typedef struct {
        logic [31:0] data;
        logic        timedOut;
        int          latency;
        int          strobes;
        int          reqEdge;
        int          strBase;
        logic [9:0]  errAddr;
        logic [7:0]  errCnt;
    } expT;

    logic         clock = 1'b0;
    logic         rstN;
    logic         dcrRead, dcrWrite;
    logic [0:9]   dcrAbus;
    logic [0:31]  dcrDout;
    logic         ack;
    logic [0:31]  dbusIn;
    logic         timeoutP;
    logic [0:3]   slvRead, slvWrite;
    logic [0:7]   slvAbus;
    logic [0:31]  slvDbus;
    logic [0:3]   slvAck;
    logic [0:127] slvRdData;
    logic [31:0]  slaveData [4];
`ifdef PPC405_DCR_ERRLOG_EN
    logic [0:9]   errAddr;
    logic [0:7]   errCnt;
`endif

    int checks = 0;
    int failures = 0;
    int cycle = 0;
    int strTotal = 0;
    int ackTotal = 0;
    int respCnt = 0;
    int planTgt = 0;
    int planDelay = -1;
    int planSpur = -1;
    int mErrCnt = 0;
    logic [9:0]  mErrAddr = 10'h0;
    logic [0:3]  curRd = 4'b0, curWr = 4'b0;
    logic [0:7]  curAbus = 8'h0;
    logic [0:31] curDbus = 32'h0;
    expT expQ[$];
    expT monTxn;

    always #5 clock = ~clock;

    assign slvRdData = {slaveData[0], slaveData[1], slaveData[2], slaveData[3]};

    ppc405_dcr_ctrl dut (
        .DCRCLK(clock), .DCRRSTNEG(rstN),
        .C405DCRREAD(dcrRead), .C405DCRWRITE(dcrWrite),
        .C405DCRABUS(dcrAbus), .C405DCRDBUSOUT(dcrDout),
        .DCRC405ACK(ack), .DCRC405DBUSIN(dbusIn), .DCRTIMEOUT(timeoutP),
        .SLVDCRREAD(slvRead), .SLVDCRWRITE(slvWrite),
        .SLVDCRABUS(slvAbus), .SLVDCRDBUS(slvDbus),
        .SLVDCRACK(slvAck), .SLVDCRRDDBUS(slvRdData)
`ifdef PPC405_DCR_ERRLOG_EN
        , .DCRERRADDR(errAddr), .DCRERRCNT(errCnt)
`endif
    );

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    always @(posedge clock) cycle <= cycle + 1;

    // Slave model: acks the planned slave after planDelay strobe cycles, optional stray ack.
    always @(negedge clock) begin
        logic [0:3] a;
        a = 4'b0000;
        if ((slvRead | slvWrite) != 4'b0000) begin
            respCnt++;
            if (planDelay >= 0 && respCnt - 1 >= planDelay) a[planTgt] = 1'b1;
            if (planSpur >= 0 && respCnt == 3) a[planSpur] = 1'b1;
        end else begin
            respCnt = 0;
        end
        slvAck = a;
    end

    // Monitor: checks strobe contents every cycle and pops the scoreboard on every ACK.
    always @(negedge clock) begin
        if ((slvRead | slvWrite) != 4'b0000) begin
            strTotal++;
            checkOutput("strobe", 64'({slvRead, slvWrite, slvAbus, slvDbus}),
                        64'({curRd, curWr, curAbus, curDbus}));
        end
        if (ack) begin
            ackTotal++;
            if (expQ.size() == 0) begin
                checkOutput("unexpected_ack", 64'(ack), 64'd0);
            end else begin
                monTxn = expQ.pop_front();
                checkOutput("ack_data", 64'(dbusIn), 64'(monTxn.data));
                checkOutput("ack_timeout", 64'(timeoutP), 64'(monTxn.timedOut));
                checkOutput("ack_latency", 64'(cycle - monTxn.reqEdge), 64'(monTxn.latency));
                checkOutput("strobe_cycles", 64'(strTotal - monTxn.strBase), 64'(monTxn.strobes));
`ifdef PPC405_DCR_ERRLOG_EN
                checkOutput("err_addr", 64'(errAddr), 64'(monTxn.errAddr));
                checkOutput("err_cnt", 64'(errCnt), 64'(monTxn.errCnt));
`endif
            end
        end else if (timeoutP) begin
            checkOutput("timeout_without_ack", 64'(timeoutP), 64'd0);
        end
    end

    task automatic applyStimulus(input int kind, input logic [0:9] addr, input logic [31:0] wdata,
                                 input int delay, input int spur);
        expT e;
        int  slv;
        int  ackBase;
        int  strBase;
        slv = int'(addr[0:1]);
        planTgt   = slv;
        planDelay = (kind == KREAD || kind == KWRITE) ? delay : -1;
        planSpur  = (kind == KSPUR) ? spur : -1;
        curRd = 4'b0000;
        curWr = 4'b0000;
        if (kind == KWRITE) curWr[slv] = 1'b1;
        else                curRd[slv] = 1'b1;
        curAbus = addr[2:9];
        curDbus = wdata;
        e.timedOut = 1'b0;
        case (kind)
            KREAD:  begin e.data = slaveData[slv]; e.latency = delay + 1; e.strobes = delay + 1; end
            KWRITE: begin e.data = wdata;          e.latency = delay + 1; e.strobes = delay + 1; end
            KBOTH:  begin e.data = TO_RDDATA;      e.latency = 0;         e.strobes = 0;         end
            default: begin
                e.data = TO_RDDATA; e.timedOut = 1'b1;
                e.latency = TIMEOUT_CYC; e.strobes = TIMEOUT_CYC;
            end
        endcase
        if (kind == KTIMEOUT || kind == KSPUR || kind == KBOTH) begin
            if (mErrCnt < 255) mErrCnt++;
            mErrAddr = addr;
        end
        e.errCnt  = 8'(mErrCnt);
        e.errAddr = mErrAddr;

        @(posedge clock); #1;
        e.reqEdge = cycle + 1;
        e.strBase = strTotal;
        strBase   = strTotal;
        ackBase   = ackTotal;
        if (kind != KABORT) expQ.push_back(e);
        dcrAbus  = addr;
        dcrDout  = wdata;
        dcrRead  = (kind != KWRITE);
        dcrWrite = (kind == KWRITE || kind == KBOTH);

        if (kind == KABORT) begin
            for (int i = 0; i < 20 && strTotal - strBase < 2; i++) @(negedge clock);
            @(posedge clock); #1;
            dcrRead  = 1'b0;
            dcrWrite = 1'b0;
            repeat (3) @(negedge clock);
            checkOutput("abort_strobes", 64'({slvRead, slvWrite}), 64'd0);
            checkOutput("abort_no_ack", 64'(ackTotal - ackBase), 64'd0);
        end else begin
            @(posedge clock); #1;
            dcrAbus = 10'($urandom);
            dcrDout = $urandom;
            for (int i = 0; i < TIMEOUT_CYC + 8 && ackTotal == ackBase; i++) @(negedge clock);
            checkOutput("ack_seen", 64'(ackTotal - ackBase), 64'd1);
            repeat (2) @(posedge clock);
            #1;
            dcrRead  = 1'b0;
            dcrWrite = 1'b0;
            repeat (2) @(negedge clock);
            checkOutput("dbus_hold", 64'(dbusIn), 64'(e.data));
        end
    endtask

    task automatic applyResetMidAccess();
        int ackBase;
        int strBase;
        planTgt = 1; planDelay = -1; planSpur = -1;
        curRd = 4'b0100; curWr = 4'b0000; curAbus = 8'h55; curDbus = 32'h0BAD_BEEF;
        @(posedge clock); #1;
        strBase  = strTotal;
        ackBase  = ackTotal;
        dcrAbus  = 10'h155;
        dcrDout  = 32'h0BAD_BEEF;
        dcrRead  = 1'b1;
        for (int i = 0; i < 20 && strTotal - strBase < 2; i++) @(negedge clock);
        #1 rstN = 1'b0;
        #1;
        checkOutput("rst_mid_strobes", 64'({slvRead, slvWrite}), 64'd0);
        checkOutput("rst_mid_ack", 64'(ack), 64'd0);
        checkOutput("rst_mid_dbus", 64'(dbusIn), 64'd0);
        mErrCnt  = 0;
        mErrAddr = 10'h0;
        dcrRead  = 1'b0;
        @(posedge clock); #1 rstN = 1'b1;
        repeat (3) @(negedge clock);
        checkOutput("rst_mid_no_ack", 64'(ackTotal - ackBase), 64'd0);
    endtask

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int kind;
        int slv;
        logic [0:9] addr;
        rstN = 1'b0;
        dcrRead = 1'b0;
        dcrWrite = 1'b0;
        dcrAbus = 10'h0;
        dcrDout = 32'h0;
        slvAck = 4'b0000;
        for (int i = 0; i < 4; i++) slaveData[i] = $urandom;
        repeat (3) @(negedge clock);
        checkOutput("reset_ack_to", 64'({ack, timeoutP}), 64'd0);
        checkOutput("reset_dbus", 64'(dbusIn), 64'd0);
        checkOutput("reset_strobes", 64'({slvRead, slvWrite}), 64'd0);
        checkOutput("reset_slv_bus", 64'({slvAbus, slvDbus}), 64'd0);
`ifdef PPC405_DCR_ERRLOG_EN
        checkOutput("reset_errlog", 64'({errAddr, errCnt}), 64'd0);
`endif
        @(posedge clock); #1 rstN = 1'b1;
        repeat (2) @(posedge clock);

        applyStimulus(KWRITE, 10'h2A5, 32'hCAFE_F00D, 0, -1);
        slaveData[0] = 32'h1234_5678;
        applyStimulus(KREAD, 10'h013, 32'h0, 3, -1);
        applyStimulus(KTIMEOUT, 10'h3FF, 32'h0, 0, -1);
        applyStimulus(KBOTH, 10'h0C4, 32'h5555_AAAA, 0, -1);
        applyStimulus(KSPUR, 10'h3A0, 32'h0, 0, 1);
        applyResetMidAccess();
        applyStimulus(KREAD, 10'h155, 32'h0, 1, -1);
        applyStimulus(KREAD, 10'h2EE, 32'h0, TIMEOUT_CYC - 1, -1);
        applyStimulus(KWRITE, 10'h1FF, 32'hFFFF_0001, TIMEOUT_CYC - 2, -1);
        applyStimulus(KABORT, 10'h0AA, 32'h0, 0, -1);

        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < 4; i++) slaveData[i] = $urandom;
            kind = int'($urandom_range(0, 5));
            addr = 10'($urandom);
            slv  = int'(addr[0:1]);
            applyStimulus(kind, addr, $urandom, int'($urandom_range(0, TIMEOUT_CYC - 1)),
                          (slv + 1 + int'($urandom_range(0, 2))) % 4);
        end

`ifdef PPC405_DCR_ERRLOG_EN
        for (int n = 0; n < 260; n++) applyStimulus(KTIMEOUT, 10'h3FF, 32'h0, 0, -1);
        checkOutput("errcnt_saturated", 64'(errCnt), 64'hFF);
`endif

        repeat (5) @(negedge clock);
        checkOutput("scoreboard_drained", 64'(expQ.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
